// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: received words queue in a circular FIFO and are replayed to the
// transmitter via a tx_start/tx_busy handshake, with optional CR->CRLF expansion.
module uart_echo_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter bit CRLF_EXPAND = 1'b0,
    parameter int DROP_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow,
    input  logic                       ovf_clear,
    output logic [DROP_W-1:0]          drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] CR_WORD = DATA_W'('h0D);
    localparam logic [DATA_W-1:0] LF_WORD = DATA_W'('h0A);

    typedef enum logic [1:0] {IDLE, START, HOLD, DRAIN} state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q,      state_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic              tx_start_q,   tx_start_d;
    logic [DATA_W-1:0] tx_data_q,    tx_data_d;
    logic              lf_pending_q, lf_pending_d;
    logic              overflow_q,   overflow_d;
    logic [DROP_W-1:0] drop_q,       drop_d;

    logic push, pop, drop;

    // NOTE: every signal assigned here gets a default at the top so no latch is inferred.
    always_comb begin
        push         = rx_valid && (count_q != FULL);
        drop         = rx_valid && (count_q == FULL);
        pop          = 1'b0;
        state_d      = state_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        lf_pending_d = lf_pending_q;

        case (state_q)
            IDLE: begin
                if (enable && (count_q != '0)) begin
                    pop        = 1'b1;
                    tx_data_d  = mem[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: state_d = HOLD;
            // Guard cycle: the transmitter raises tx_busy by now at the latest.
            HOLD:  state_d = DRAIN;
            DRAIN: begin
                if (!tx_busy) begin
                    if (CRLF_EXPAND && (tx_data_q == CR_WORD) && !lf_pending_q) begin
                        tx_data_d    = LF_WORD;
                        lf_pending_d = 1'b1;
                        tx_start_d   = 1'b1;
                        state_d      = START;
                    end else begin
                        lf_pending_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (ovf_clear) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    // NOTE: storage array has no reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

    // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            lf_pending_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            lf_pending_q <= lf_pending_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: instance 0 default, 1 with CRLF expansion, 2 with DEPTH=4.
`timescale 1ns/1ps
module tb_uart_echo_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       en   [3];
    logic       rxv  [3];
    logic       clr  [3];
    logic [7:0] rxd  [3];
    logic       busy [3] = '{1'b0, 1'b0, 1'b0};
    logic       start[3];
    logic       ovf  [3];
    logic [7:0] txd  [3];
    logic [7:0] drop [3];
    logic [4:0] lvl_a, lvl_b;
    logic [2:0] lvl_c;

    always #5 clk = ~clk;

    uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .CRLF_EXPAND(1'b0), .DROP_W(8)) u_a (
        .clk(clk), .rst(rst), .enable(en[0]), .rx_valid(rxv[0]), .rx_data(rxd[0]),
        .tx_busy(busy[0]), .tx_start(start[0]), .tx_data(txd[0]), .fifo_level(lvl_a),
        .overflow(ovf[0]), .ovf_clear(clr[0]), .drop_count(drop[0]));
    uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .CRLF_EXPAND(1'b1), .DROP_W(8)) u_b (
        .clk(clk), .rst(rst), .enable(en[1]), .rx_valid(rxv[1]), .rx_data(rxd[1]),
        .tx_busy(busy[1]), .tx_start(start[1]), .tx_data(txd[1]), .fifo_level(lvl_b),
        .overflow(ovf[1]), .ovf_clear(clr[1]), .drop_count(drop[1]));
    uart_echo_fifo #(.DATA_W(8), .DEPTH(4), .CRLF_EXPAND(1'b0), .DROP_W(8)) u_c (
        .clk(clk), .rst(rst), .enable(en[2]), .rx_valid(rxv[2]), .rx_data(rxd[2]),
        .tx_busy(busy[2]), .tx_start(start[2]), .tx_data(txd[2]), .fifo_level(lvl_c),
        .overflow(ovf[2]), .ovf_clear(clr[2]), .drop_count(drop[2]));

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] data;
    } tx_rec_t;

    typedef struct {
        logic       rxv;
        logic [7:0] rxd;
        logic       exp_start;
        logic [7:0] exp_data;
        logic [4:0] exp_level;
    } vec_t;

    tx_rec_t txlog[$];
    int      cyc = 0;
    int      busy_len[3] = '{1, 1, 1};
    int      busy_cnt[3] = '{0, 0, 0};
    logic    hold_bad[3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] last_tx[3];
    int      max_c = 0;
    int      n_pass = 0;
    int      n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model and tx monitor: busy for busy_len half-to-half cycles after tx_start.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                busy_cnt[i] = 0;
            end else if (start[i]) begin
                txlog.push_back('{inst: i, cyc: cyc, data: txd[i]});
                last_tx[i]  = txd[i];
                busy_cnt[i] = busy_len[i];
            end else if (busy_cnt[i] > 0) begin
                if (txd[i] !== last_tx[i]) hold_bad[i] = 1'b1;
                busy_cnt[i] = busy_cnt[i] - 1;
            end
            busy[i] = (busy_cnt[i] != 0);
        end
        if (int'(lvl_c) > max_c) max_c = int'(lvl_c);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [7:0] d);
        rxv[inst] = 1'b1;
        rxd[inst] = d;
        tick();
        rxv[inst] = 1'b0;
    endtask

    function automatic int count_tx(input int inst);
        int n = 0;
        foreach (txlog[j]) if (txlog[j].inst == inst) n++;
        return n;
    endfunction

    function automatic tx_rec_t get_tx(input int inst, input int idx);
        tx_rec_t r = '{inst: -1, cyc: -1, data: 8'h00};
        int n = 0;
        foreach (txlog[j]) begin
            if (txlog[j].inst == inst) begin
                if (n == idx) r = txlog[j];
                n++;
            end
        end
        return r;
    endfunction

    task automatic wait_tx(input string name, input int inst, input int n, input int budget);
        for (int k = 0; k < budget && count_tx(inst) < n; k++) tick();
        check(name, count_tx(inst), n);
    endtask

    vec_t sb_vec[8];

    initial begin
        tx_rec_t r, p;
        int sent;

        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; rxv[i] = 1'b0; clr[i] = 1'b0; rxd[i] = 8'h00;
        end

        // Single byte: row k = inputs driven in cycle k, outputs expected in cycle k.
        sb_vec[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 5'd0};
        sb_vec[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd1};
        sb_vec[2] = '{1'b0, 8'h00, 1'b1, 8'h41, 5'd0};
        sb_vec[3] = '{1'b0, 8'h00, 1'b0, 8'h41, 5'd0};
        sb_vec[4] = '{1'b0, 8'h00, 1'b0, 8'h41, 5'd0};
        sb_vec[5] = '{1'b0, 8'h00, 1'b0, 8'h41, 5'd0};
        sb_vec[6] = '{1'b0, 8'h00, 1'b0, 8'h41, 5'd0};
        sb_vec[7] = '{1'b0, 8'h00, 1'b0, 8'h41, 5'd0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tx_start", start[0], 0);
        check("rst_tx_data", txd[0], 0);
        check("rst_level", lvl_a, 0);
        check("rst_overflow", ovf[0], 0);
        check("rst_drop", drop[0], 0);
        check("rst_level_c", lvl_c, 0);
        tick();

        // Single byte, UART busy 20 cycles.
        en[0] = 1'b1;
        busy_len[0] = 20;
        for (int k = 0; k < 8; k++) begin
            rxv[0] = sb_vec[k].rxv;
            rxd[0] = sb_vec[k].rxd;
            @(negedge clk);
            check($sformatf("sb_start[%0d]", k), start[0], sb_vec[k].exp_start);
            check($sformatf("sb_data[%0d]", k), txd[0], sb_vec[k].exp_data);
            check($sformatf("sb_level[%0d]", k), lvl_a, sb_vec[k].exp_level);
            tick();
        end
        rxv[0] = 1'b0;
        repeat (30) tick();
        check("sb_one_pulse", count_tx(0), 1);

        // Burst of 16 consecutive words, UART busy 100 cycles per word.
        txlog.delete();
        busy_len[0] = 100;
        for (int i = 0; i < 16; i++) push(0, 8'(i));
        wait_tx("burst_count", 0, 16, 3000);
        for (int i = 0; i < 16; i++) begin
            r = get_tx(0, i);
            check($sformatf("burst_data[%0d]", i), r.data, i);
        end
        @(negedge clk);
        check("burst_overflow", ovf[0], 0);
        check("burst_drop", drop[0], 0);
        tick();

        // Overflow with transmitter disabled.
        en[0] = 1'b0;
        for (int i = 0; i < 20; i++) push(0, 8'h20 + 8'(i));
        @(negedge clk);
        check("ovf_level", lvl_a, 16);
        check("ovf_drop", drop[0], 4);
        check("ovf_flag", ovf[0], 1);
        tick();
        // Clear in the same cycle as a drop: clear wins, drop not counted.
        rxv[0] = 1'b1; rxd[0] = 8'hEE; clr[0] = 1'b1;
        tick();
        rxv[0] = 1'b0; clr[0] = 1'b0;
        @(negedge clk);
        check("clr_drop_flag", ovf[0], 0);
        check("clr_drop_count", drop[0], 0);
        check("clr_drop_level", lvl_a, 16);
        tick();
        for (int i = 0; i < 260; i++) push(0, 8'hEE);
        @(negedge clk);
        check("sat_drop", drop[0], 8'hFF);
        check("sat_flag", ovf[0], 1);
        tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        @(negedge clk);
        check("clear_flag", ovf[0], 0);
        check("clear_drop", drop[0], 0);
        tick();
        txlog.delete();
        busy_len[0] = 1;
        en[0] = 1'b1;
        wait_tx("ovf_tx_count", 0, 16, 500);
        for (int i = 0; i < 16; i++) begin
            r = get_tx(0, i);
            check($sformatf("ovf_tx_data[%0d]", i), r.data, 8'h20 + 8'(i));
            if (i > 0) begin
                p = get_tx(0, i - 1);
                check($sformatf("ovf_tx_gap[%0d]", i), r.cyc - p.cyc, 4);
            end
        end
        repeat (10) tick();
        @(negedge clk);
        check("ovf_drained_level", lvl_a, 0);
        tick();

        // No CRLF expansion on instance 0.
        txlog.delete();
        push(0, 8'h0D);
        push(0, 8'h42);
        wait_tx("nocrlf_wait", 0, 2, 200);
        repeat (20) tick();
        check("nocrlf_count", count_tx(0), 2);
        r = get_tx(0, 0); check("nocrlf_w0", r.data, 8'h0D);
        r = get_tx(0, 1); check("nocrlf_w1", r.data, 8'h42);

        // CRLF expansion on instance 1.
        en[1] = 1'b1;
        push(1, 8'h0D);
        push(1, 8'h42);
        wait_tx("crlf_wait", 1, 3, 200);
        repeat (20) tick();
        check("crlf_count", count_tx(1), 3);
        r = get_tx(1, 0); check("crlf_w0", r.data, 8'h0D);
        p = r;
        r = get_tx(1, 1); check("crlf_w1", r.data, 8'h0A);
        check("crlf_lf_gap", r.cyc - p.cyc, 3);
        p = r;
        r = get_tx(1, 2); check("crlf_w2", r.data, 8'h42);
        check("crlf_next_gap", r.cyc - p.cyc, 4);

        // Enable dropped right after CR starts: the LF still follows, nothing new is popped.
        txlog.delete();
        push(1, 8'h0D);
        wait_tx("en_cr_wait", 1, 1, 20);
        en[1] = 1'b0;
        push(1, 8'h43);
        repeat (40) tick();
        check("en_off_count", count_tx(1), 2);
        r = get_tx(1, 1); check("en_off_lf", r.data, 8'h0A);
        @(negedge clk);
        check("en_off_level", lvl_b, 1);
        tick();
        en[1] = 1'b1;
        wait_tx("en_on_wait", 1, 3, 50);
        r = get_tx(1, 2); check("en_on_data", r.data, 8'h43);

        // DEPTH=4 wrap: five back-to-back words then one every 4 cycles, off the pop phase.
        en[2] = 1'b1;
        sent = 0;
        for (int k = 0; sent < 50; k++) begin
            if (k < 5 || (k >= 6 && (k - 6) % 4 == 0)) begin
                rxv[2] = 1'b1;
                rxd[2] = 8'h80 + 8'(sent);
                sent++;
            end else begin
                rxv[2] = 1'b0;
            end
            tick();
        end
        rxv[2] = 1'b0;
        wait_tx("wrap_count", 2, 50, 400);
        for (int i = 0; i < 50; i++) begin
            r = get_tx(2, i);
            check($sformatf("wrap_data[%0d]", i), r.data, 8'h80 + 8'(i));
        end
        @(negedge clk);
        check("wrap_drop", drop[2], 0);
        check("wrap_overflow", ovf[2], 0);
        check("wrap_max_level", max_c, 4);
        tick();

        // Reset while draining with three words queued.
        txlog.delete();
        busy_len[0] = 50;
        for (int i = 0; i < 4; i++) push(0, 8'h51 + 8'(i));
        repeat (8) tick();
        @(negedge clk);
        check("pre_rst_level", lvl_a, 3);
        check("pre_rst_count", count_tx(0), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", lvl_a, 0);
        check("post_rst_start", start[0], 0);
        check("post_rst_data", txd[0], 0);
        tick();
        repeat (60) tick();
        check("post_rst_no_tx", count_tx(0), 1);

        for (int i = 0; i < 3; i++) check($sformatf("hold_stable[%0d]", i), hold_bad[i], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
